// File: rtl/operand_issue.sv
// operand_issue -- decode/issue stage in front of the register file.
//
// Drives the regfile read addresses from the incoming instruction, picks the
// operands (x0 -> 0, same-cycle writeback bypass, else regfile data) and
// captures them in a one-entry issue register for execute. A per-register
// write-pending scoreboard stalls RAW and WAW hazards at issue.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         decoded instruction handshake
//   in_rs1/in_rs2/in_use_*    source addresses and read enables
//   in_rd/in_rd_we            destination and write enable
//   read_addr1/2, read_data1/2  regfile read port (combinational)
//   wb_en/wb_addr/wb_data     writeback snoop (same nets as regfile write port)
//   flush                     kill the held instruction
//   out_valid/out_ready       issue register handshake toward execute
//   out_op1/out_op2/out_rd/out_rd_we  held instruction
//
// Optional: define OPERAND_ISSUE_PERF_EN to add saturating 32-bit counters
// stall_cycles (in_valid && !in_ready) and issued (accepted instructions).

module operand_issue #(
   parameter int n = 32,
   parameter int r = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [r-1:0] in_rs1,
   input  logic [r-1:0] in_rs2,
   input  logic         in_use_rs1,
   input  logic         in_use_rs2,
   input  logic [r-1:0] in_rd,
   input  logic         in_rd_we,
   output logic [r-1:0] read_addr1,
   output logic [r-1:0] read_addr2,
   input  logic [n-1:0] read_data1,
   input  logic [n-1:0] read_data2,
   input  logic         wb_en,
   input  logic [r-1:0] wb_addr,
   input  logic [n-1:0] wb_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] out_op1,
   output logic [n-1:0] out_op2,
   output logic [r-1:0] out_rd,
`ifdef OPERAND_ISSUE_PERF_EN
   output logic [31:0]  stall_cycles,
   output logic [31:0]  issued,
`endif
   output logic         out_rd_we
);

   localparam int NReg = 2 ** r;

   logic [NReg-1:0] busy_q;
   logic [NReg-1:0] busy_d;
   logic [NReg-1:0] busy_eff;
   logic            wb_clr;
   logic            hazard;
   logic            in_fire;
   logic            flush_clr;
   logic [n-1:0]    op1_sel;
   logic [n-1:0]    op2_sel;

   assign read_addr1 = in_rs1;
   assign read_addr2 = in_rs2;

   assign wb_clr = wb_en && (wb_addr != '0);

   // A writeback landing this cycle already resolves the pending write.
   always_comb begin
      busy_eff = '0;
      for (int i = 0; i < NReg; i++) begin
         busy_eff[i] = busy_q[i] && !(wb_clr && (wb_addr == r'(i)));
      end
   end

   assign hazard = (in_use_rs1 && busy_eff[in_rs1]) ||
                   (in_use_rs2 && busy_eff[in_rs2]) ||
                   (in_rd_we   && busy_eff[in_rd]);

   assign in_ready = !hazard && !flush && (!out_valid || out_ready);
   assign in_fire  = in_valid && in_ready;

   // Regfile has no write-to-read forwarding, so bypass the writeback here.
   always_comb begin
      op1_sel = read_data1;
      if (in_rs1 == '0) begin
         op1_sel = '0;
      end else if (wb_en && (wb_addr == in_rs1)) begin
         op1_sel = wb_data;
      end
   end

   always_comb begin
      op2_sel = read_data2;
      if (in_rs2 == '0) begin
         op2_sel = '0;
      end else if (wb_en && (wb_addr == in_rs2)) begin
         op2_sel = wb_data;
      end
   end

   // Dropping a flushed writer's busy bit is safe: WAW stalls guarantee no
   // older writer of the same register is still in flight.
   assign flush_clr = flush && out_valid && out_rd_we && (out_rd != '0);

   always_comb begin
      busy_d = busy_q;
      if (wb_clr) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (flush_clr) begin
         busy_d[out_rd] = 1'b0;
      end
      // Set is applied last so it wins over a same-address clear.
      if (in_fire && in_rd_we && (in_rd != '0)) begin
         busy_d[in_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_rd    <= '0;
         out_rd_we <= 1'b0;
      end else if (flush) begin
         // in_ready is low during flush, so nothing can fire this cycle.
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         out_op1   <= op1_sel;
         out_op2   <= op2_sel;
         out_rd    <= in_rd;
         out_rd_we <= in_rd_we;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OPERAND_ISSUE_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         issued       <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (in_fire && (issued != 32'hFFFF_FFFF)) begin
            issued <= issued + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_operand_issue.sv
module tb_operand_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_use_rs1, in_use_rs2, in_rd_we;
   logic [4:0]  read_addr1, read_addr2;
   logic [31:0] read_data1, read_data2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_op1, out_op2;
   logic [4:0]  out_rd;
   logic        out_rd_we;
`ifdef OPERAND_ISSUE_PERF_EN
   logic [31:0] stall_cycles, issued;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   operand_issue #(.n(32), .r(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_use_rs1 (in_use_rs1),
      .in_use_rs2 (in_use_rs2),
      .in_rd      (in_rd),
      .in_rd_we   (in_rd_we),
      .read_addr1 (read_addr1),
      .read_addr2 (read_addr2),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op1    (out_op1),
      .out_op2    (out_op2),
      .out_rd     (out_rd),
`ifdef OPERAND_ISSUE_PERF_EN
      .stall_cycles (stall_cycles),
      .issued       (issued),
`endif
      .out_rd_we  (out_rd_we)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present an instruction; inputs change 1 time unit after a posedge.
   task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we);
      in_valid   = 1'b1;
      in_rs1     = rs1;
      in_use_rs1 = u1;
      in_rs2     = rs2;
      in_use_rs2 = u2;
      in_rd      = rd;
      in_rd_we   = we;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
      in_rd = 0; in_rd_we = 0; read_data1 = 0; read_data2 = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
      tick; tick;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_op1", out_op1, 32'd0);
      check("rst_out_op2", out_op2, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_out_rd_we", 32'(out_rd_we), 32'd0);
      rst = 1'b0;

      // Basic issue: rs2=x0 must read as zero regardless of regfile data.
      present(5'd3, 1, 5'd0, 1, 5'd0, 0);
      read_data1 = 32'h11; read_data2 = 32'h77;
      #1;
      check("t1_in_ready", 32'(in_ready), 32'd1);
      check("t1_read_addr1", 32'(read_addr1), 32'd3);
      tick;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_op1", out_op1, 32'h11);
      check("t1_op2", out_op2, 32'h0);
      // No register should look busy.
      in_valid = 0; in_use_rs2 = 0; in_use_rs1 = 1;
      for (int i = 0; i < 32; i++) begin
         in_rs1 = 5'(i);
         #1;
         check($sformatf("t1_clear_x%0d", i), 32'(in_ready), 32'd1);
      end

      // RAW on x5, resolved by a same-cycle writeback with bypass.
      present(5'd1, 1, 5'd0, 0, 5'd5, 1);
      read_data1 = 32'h21;
      tick;
      check("t2_out_rd", 32'(out_rd), 32'd5);
      check("t2_out_rd_we", 32'(out_rd_we), 32'd1);
      present(5'd5, 1, 5'd0, 0, 5'd0, 0);
      read_data1 = 32'h1234;
      #1;
      check("t2_raw_stall", 32'(in_ready), 32'd0);
      tick;
      check("t2_drained", 32'(out_valid), 32'd0);
      wb_en = 1; wb_addr = 5'd5; wb_data = 32'hABCD;
      #1;
      check("t2_wb_ready", 32'(in_ready), 32'd1);
      tick;
      wb_en = 0;
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_bypass_op1", out_op1, 32'hABCD);

      // Bypass with no pending write.
      present(5'd0, 0, 5'd7, 1, 5'd0, 0);
      read_data2 = 32'h99;
      wb_en = 1; wb_addr = 5'd7; wb_data = 32'h55;
      #1;
      check("t3_in_ready", 32'(in_ready), 32'd1);
      tick;
      wb_en = 0;
      check("t3_bypass_op2", out_op2, 32'h55);

      // WAW on x9, released by flushing the held writer.
      present(5'd0, 0, 5'd0, 0, 5'd9, 1);
      tick;
      check("t4_first_rd", 32'(out_rd), 32'd9);
      #1;
      check("t4_waw_stall", 32'(in_ready), 32'd0);
      flush = 1;
      #1;
      check("t4_flush_ready", 32'(in_ready), 32'd0);
      tick;
      flush = 0;
      check("t4_flushed", 32'(out_valid), 32'd0);
      #1;
      check("t4_after_flush_ready", 32'(in_ready), 32'd1);
      tick;
      check("t4_second_valid", 32'(out_valid), 32'd1);
      check("t4_second_rd", 32'(out_rd), 32'd9);
      in_valid = 0;
      wb_en = 1; wb_addr = 5'd9; wb_data = 32'h0;
      tick;
      wb_en = 0;

      // Backpressure holds the issue register stable.
      out_ready = 0;
      present(5'd2, 1, 5'd0, 0, 5'd0, 0);
      read_data1 = 32'h42;
      tick;
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_op1", out_op1, 32'h42);
      present(5'd3, 1, 5'd0, 0, 5'd0, 0);
      read_data1 = 32'h99;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("t5_bp_ready_%0d", c), 32'(in_ready), 32'd0);
         tick;
         check($sformatf("t5_bp_valid_%0d", c), 32'(out_valid), 32'd1);
         check($sformatf("t5_bp_op1_%0d", c), out_op1, 32'h42);
      end
      out_ready = 1;
      #1;
      check("t5_release_ready", 32'(in_ready), 32'd1);
      tick;
      check("t5_next_op1", out_op1, 32'h99);

      // Writes to x0 never set busy; x0 sources read as zero.
      present(5'd0, 0, 5'd0, 0, 5'd0, 1);
      tick;
      present(5'd0, 1, 5'd0, 0, 5'd0, 1);
      read_data1 = 32'hFF;
      #1;
      check("t6_x0_ready", 32'(in_ready), 32'd1);
      tick;
      check("t6_x0_op1", out_op1, 32'h0);

      // Asynchronous reset in the middle of a RAW stall.
      present(5'd0, 0, 5'd0, 0, 5'd12, 1);
      tick;
      present(5'd12, 1, 5'd0, 0, 5'd0, 0);
      read_data1 = 32'hC0DE;
      #1;
      check("t7_stall", 32'(in_ready), 32'd0);
      rst = 1;
      #1;
      check("t7_rst_valid", 32'(out_valid), 32'd0);
      check("t7_rst_rd_we", 32'(out_rd_we), 32'd0);
      check("t7_rst_ready", 32'(in_ready), 32'd1);
      tick;
      rst = 0;
      #1;
      check("t7_post_ready", 32'(in_ready), 32'd1);
      tick;
      check("t7_post_op1", out_op1, 32'hC0DE);

`ifdef OPERAND_ISSUE_PERF_EN
      // Counters restarted at the reset: one issue so far.
      present(5'd0, 0, 5'd0, 0, 5'd13, 1);
      tick;
      present(5'd13, 1, 5'd0, 0, 5'd0, 0);
      tick; tick; tick;
      check("perf_stall_cycles", stall_cycles, 32'd3);
      check("perf_issued", issued, 32'd2);
      in_valid = 0;
`endif

      in_valid = 0;
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
